// File: rtl/alu_iter_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the iterative ALU.
// SAT_ARITH_EN (optional macro) selects saturating arithmetic in alu_arith.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_NAND = 3'b010,
    OP_XOR  = 3'b011,
    OP_INC  = 3'b100,
    OP_SRA  = 3'b101,
    OP_SRL  = 3'b110,
    OP_SLL  = 3'b111
  } alu_op_t;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SRA) || (op == OP_SRL) || (op == OP_SLL);
  endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Request/response handshake bundle between the pipeline and alu_iter.
// master = issuing pipeline stage, slave = the ALU.
interface alu_iter_if #(
  parameter int WIDTH = 16
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] data_one;
  logic [WIDTH-1:0] data_two;
  logic [SHW-1:0]   shift;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [2:0]       flags;

  modport master (
    output in_valid, op, data_one, data_two, shift, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op, data_one, data_two, shift, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_iter_arith.sv
// Combinational ADD/SUB/INC/NAND/XOR datapath with {Z,V,N} generation.
// Defining SAT_ARITH_EN clamps overflowing ADD/SUB/INC to the signed limits.
module alu_arith
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic [2:0]       flags
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] raw;
  logic             cin;
  logic             ovf;
  logic             arith;

  // SUB reuses the adder as A + ~B + 1; overflow is same-sign inputs giving an opposite-sign sum
  always_comb begin
    arith = (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC);
    b_eff = (op == OP_SUB) ? ~b : b;
    cin   = (op == OP_SUB);
    sum   = a + b_eff + {{(WIDTH-1){1'b0}}, cin};
    ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    case (op)
      OP_NAND: raw = ~(a & b);
      OP_XOR:  raw = a ^ b;
      default: raw = sum;
    endcase

    res = raw;
`ifdef SAT_ARITH_EN
    if (arith && ovf)
      res = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
`endif

    flags         = '0;
    flags[FLAG_Z] = (res == '0);
    flags[FLAG_V] = arith && ovf;
    flags[FLAG_N] = arith && res[WIDTH-1];
  end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle ALU: single-cycle arithmetic/logic, one-bit-per-cycle shifts,
// valid/ready on both sides. SAT_ARITH_EN is honoured inside alu_arith.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic        clk,
  input logic        rst,
  alu_iter_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]       state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] step;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] result_q;
  logic [2:0]       flags_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] arith_res;
  logic [2:0]       arith_flags;

  alu_arith #(.WIDTH(WIDTH)) u_arith (
    .op    (bus.op),
    .a     (bus.data_one),
    .b     (bus.data_two),
    .res   (arith_res),
    .flags (arith_flags)
  );

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

  always_comb begin
    case (op_q)
      OP_SRA:  step = {work[WIDTH-1], work[WIDTH-1:1]};
      OP_SRL:  step = {1'b0, work[WIDTH-1:1]};
      default: step = {work[WIDTH-2:0], 1'b0};
    endcase
  end

  // Shifts only touch result when they finish, so flags from the last arithmetic op survive them
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      work        <= '0;
      op_q        <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q <= bus.op;
            work <= bus.data_one;
            cnt  <= bus.shift;
            if (!is_shift(bus.op)) begin
              result_q    <= arith_res;
              flags_q     <= arith_flags;
              out_valid_q <= 1'b1;
              state       <= S_DONE;
            end else if (bus.shift == '0) begin
              result_q    <= bus.data_one;
              out_valid_q <= 1'b1;
              state       <= S_DONE;
            end else begin
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          work <= step;
          cnt  <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            result_q    <= step;
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter (WIDTH=16); expectations follow
// SAT_ARITH_EN when it is defined for the build.
module tb_alu_iter;
  import alu_pkg::*;

  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;

  alu_iter_if #(.WIDTH(WIDTH)) bus ();

  alu_iter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // extra = edges after the accept edge before out_valid shows (0 for non-shift / shift==0)
  task automatic applyStimulus(input string tag, input logic [2:0] op,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] sh, input int hold,
                               input logic [15:0] exp_res, input logic [2:0] exp_flags,
                               input int extra, input bit req_at_release);
    int lat;
    @(negedge clk);
    bus.op        = op;
    bus.data_one  = a;
    bus.data_two  = b;
    bus.shift     = sh;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    checkOutput({tag, "_in_ready_idle"}, 16'(bus.in_ready), 16'h1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.data_one = ~a;
    bus.data_two = ~b;
    bus.shift    = ~sh;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 16'(lat), 16'(extra));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput({tag, "_hold_result"}, bus.result, exp_res);
      checkOutput({tag, "_hold_in_ready"}, 16'(bus.in_ready), 16'h0);
    end
    checkOutput({tag, "_result"}, bus.result, exp_res);
    checkOutput({tag, "_flags"}, 16'(bus.flags), 16'(exp_flags));
    @(negedge clk);
    bus.out_ready = 1'b1;
    if (req_at_release) begin
      bus.op       = OP_XOR;
      bus.data_one = 16'h1234;
      bus.data_two = 16'h4321;
      bus.in_valid = 1'b1;
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, "_in_ready_after"}, 16'(bus.in_ready), 16'h1);
    checkOutput({tag, "_out_valid_after"}, 16'(bus.out_valid), 16'h0);
  endtask

  initial begin
    // Requests presented during reset must be ignored
    bus.in_valid  = 1'b1;
    bus.op        = OP_ADD;
    bus.data_one  = 16'h0001;
    bus.data_two  = 16'h0001;
    bus.shift     = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 16'(bus.in_ready), 16'h1);
    checkOutput("reset_out_valid", 16'(bus.out_valid), 16'h0);
    checkOutput("reset_result", bus.result, 16'h0000);
    checkOutput("reset_flags", 16'(bus.flags), 16'h0);
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;

`ifdef SAT_ARITH_EN
    applyStimulus("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 4'd0, 0, 16'h7FFF, 3'b010, 0, 1'b0);
`else
    applyStimulus("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 4'd0, 0, 16'h8000, 3'b011, 0, 1'b0);
`endif
    applyStimulus("sub_zero", OP_SUB, 16'h0005, 16'h0005, 4'd0, 0, 16'h0000, 3'b100, 0, 1'b1);
`ifdef SAT_ARITH_EN
    applyStimulus("sub_ovf", OP_SUB, 16'h8000, 16'h0001, 4'd0, 0, 16'h8000, 3'b011, 0, 1'b0);
`else
    applyStimulus("sub_ovf", OP_SUB, 16'h8000, 16'h0001, 4'd0, 0, 16'h7FFF, 3'b010, 0, 1'b0);
`endif
    applyStimulus("add_wrap0", OP_ADD, 16'hFFFF, 16'h0001, 4'd0, 0, 16'h0000, 3'b100, 0, 1'b0);
    applyStimulus("sra15", OP_SRA, 16'h8000, 16'h5555, 4'd15, 0, 16'hFFFF, 3'b100, 15, 1'b0);
    applyStimulus("sll0", OP_SLL, 16'h0001, 16'h0000, 4'd0, 0, 16'h0001, 3'b100, 0, 1'b0);
    applyStimulus("srl4", OP_SRL, 16'h8000, 16'h0000, 4'd4, 0, 16'h0800, 3'b100, 4, 1'b0);
    applyStimulus("inc", OP_INC, 16'h0010, 16'h0003, 4'd0, 0, 16'h0013, 3'b000, 0, 1'b0);
    applyStimulus("nand_bp", OP_NAND, 16'hFFFF, 16'hFFFF, 4'd0, 5, 16'h0000, 3'b100, 0, 1'b0);
    applyStimulus("sll5", OP_SLL, 16'h00F3, 16'h0000, 4'd5, 0, 16'h1E60, 3'b100, 5, 1'b0);

    // Abort a long SRL partway through with reset
    @(negedge clk);
    bus.op       = OP_SRL;
    bus.data_one = 16'hABCD;
    bus.shift    = 4'd10;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    checkOutput("midshift_in_ready_busy", 16'(bus.in_ready), 16'h0);
    checkOutput("midshift_out_valid_busy", 16'(bus.out_valid), 16'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midshift_rst_out_valid", 16'(bus.out_valid), 16'h0);
    checkOutput("midshift_rst_result", bus.result, 16'h0000);
    checkOutput("midshift_rst_flags", 16'(bus.flags), 16'h0);
    checkOutput("midshift_rst_in_ready", 16'(bus.in_ready), 16'h1);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("xor", OP_XOR, 16'h00FF, 16'h0F0F, 4'd0, 0, 16'h0FF0, 3'b000, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
